rx_frame_buffer: RTL and testbench

Parametrised successor to the single-instruction SPI receive stage. Captures DATA_W-bit words from the SPI front end on synchronised spi_clk rising edges and assembles NUM_BYTES-word instruction frames. Completed frames are queued in a DEPTH-entry first-word-fall-through FIFO and released to decode via a valid/ready handshake. Adds input synchronisation, partial-frame abort on spi_w deassert, and explicit overflow reporting.

---
 rtl/rx_pkg.sv | 18 +
 rtl/rx_frame_fifo.sv | 62 ++++++
 rtl/rx_frame_buffer.sv | 128 ++++++++++++
 tb/tb_rx_frame_buffer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared definitions for the SPI receive frame buffer.
// Holds the default geometry, the word positions inside an instruction
// frame and the packed frame type used by the buffer and its users.
package rx_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int NUM_BYTES_DEF = 5;

  // Word positions inside a frame (word k sits at [k*DATA_W +: DATA_W]).
  localparam int OP_IDX = 0;
  localparam int A1_IDX = 1;
  localparam int A2_IDX = 2;
  localparam int B1_IDX = 3;
  localparam int B2_IDX = 4;

  typedef logic [NUM_BYTES_DEF*DATA_W_DEF-1:0] frame_t;

endpackage

// File: rtl/rx_frame_fifo.sv
// Generic first-word-fall-through FIFO; head word visible whenever non-empty.
// Latency: a push is visible at the head on the cycle after it is accepted.
// Backpressure: push refused when full unless a pop happens the same cycle.
// Ports: push_i/push_dat_i write side, push_ok_o acceptance,
//        pop_i read strobe, head_vld_o/head_dat_o head entry, level_o occupancy.
module rx_frame_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  output logic                       push_ok_o,
  input  logic                       pop_i,
  output logic                       head_vld_o,
  output logic [WIDTH-1:0]           head_dat_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [LVL_W-1:0] cnt_q;
  logic             empty, full, pop_ok, push_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == LVL_W'(DEPTH));
  assign pop_ok  = pop_i & ~empty;
  // When full, a same-cycle pop frees the head slot, which is exactly the
  // slot wr_ptr points at, so the new entry lands behind the rest.
  assign push_ok = push_i & (~full | pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + LVL_W'(1);
        2'b01:   cnt_q <= cnt_q - LVL_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign push_ok_o  = push_ok;
  assign head_vld_o = ~empty;
  // Stale storage is never exposed: the head reads as zero while empty.
  assign head_dat_o = empty ? '0 : mem_q[rd_ptr_q];
  assign level_o    = cnt_q;

endmodule

// File: rtl/rx_frame_buffer.sv
// Assembles SPI MOSI words into NUM_BYTES-word frames and queues them for decode.
// Latency: frame_valid SYNC_STAGES+1 clk edges after the final spi_clk high is first sampled.
// Backpressure: frame_ready pops the head; a frame completing into a full FIFO without a pop is dropped (overflow).
// Ports: spi_clk/spi_w/mosi async SPI inputs; frame_valid/frame_ready/frame_data decode handshake;
//        level occupancy, rx_busy partial frame, frame_abort and overflow single-cycle pulses.
module rx_frame_buffer
  import rx_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int NUM_BYTES   = NUM_BYTES_DEF,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          spi_clk,
  input  logic                          spi_w,
  input  logic [DATA_W-1:0]             mosi,
  input  logic                          frame_ready,
  output logic                          frame_valid,
  output logic [NUM_BYTES*DATA_W-1:0]   frame_data,
  output logic [$clog2(DEPTH+1)-1:0]    level,
  output logic                          rx_busy,
  output logic                          frame_abort,
  output logic                          overflow
);

  localparam int FRAME_W = NUM_BYTES * DATA_W;
  localparam int IDX_W   = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  // Identical chains keep spi_clk, spi_w and mosi cycle-aligned.
  logic [SYNC_STAGES-1:0]             clk_sync_q, w_sync_q;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] mosi_sync_q;
  logic                               s_clk, s_w;
  logic [DATA_W-1:0]                  s_mosi;

  logic                               clk_prev_q, w_prev_q;
  logic                               rise, w_fall, capture;
  logic [IDX_W-1:0]                   word_idx_q, word_idx_d;
  logic [NUM_BYTES-2:0][DATA_W-1:0]   slot_q, slot_d;
  logic                               stage_vld_q, stage_vld_d;
  logic [FRAME_W-1:0]                 stage_dat_q, stage_dat_d;
  logic                               abort_q, abort_d;
  logic                               ovf_q;
  logic                               fifo_push_ok;

  assign s_clk  = clk_sync_q[SYNC_STAGES-1];
  assign s_w    = w_sync_q[SYNC_STAGES-1];
  assign s_mosi = mosi_sync_q[SYNC_STAGES-1];

  always_comb begin
    rise        = s_clk & ~clk_prev_q;
    w_fall      = ~s_w & w_prev_q;
    capture     = rise & s_w;
    word_idx_d  = word_idx_q;
    slot_d      = slot_q;
    stage_vld_d = 1'b0;
    stage_dat_d = stage_dat_q;
    abort_d     = 1'b0;
    if (w_fall && word_idx_q != '0) begin
      word_idx_d = '0;
      slot_d     = '0;
      abort_d    = 1'b1;
    end else if (capture) begin
      if (word_idx_q == LAST_IDX) begin
        // Final word goes straight into the completed frame with the slots.
        word_idx_d  = '0;
        stage_vld_d = 1'b1;
        stage_dat_d = {s_mosi, slot_q};
      end else begin
        word_idx_d = word_idx_q + 1'b1;
        for (int k = 0; k < NUM_BYTES - 1; k++) begin
          if (word_idx_q == IDX_W'(k)) slot_d[k] = s_mosi;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= '0;
      w_sync_q    <= '0;
      mosi_sync_q <= '0;
      clk_prev_q  <= 1'b0;
      w_prev_q    <= 1'b0;
      word_idx_q  <= '0;
      slot_q      <= '0;
      stage_vld_q <= 1'b0;
      stage_dat_q <= '0;
      abort_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], spi_clk};
      w_sync_q    <= {w_sync_q[SYNC_STAGES-2:0], spi_w};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      clk_prev_q  <= s_clk;
      w_prev_q    <= s_w;
      word_idx_q  <= word_idx_d;
      slot_q      <= slot_d;
      stage_vld_q <= stage_vld_d;
      stage_dat_q <= stage_dat_d;
      abort_q     <= abort_d;
      // The push decision is made in the cycle the staged frame is offered.
      ovf_q       <= stage_vld_q & ~fifo_push_ok;
    end
  end

  rx_frame_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (stage_vld_q),
    .push_dat_i (stage_dat_q),
    .push_ok_o  (fifo_push_ok),
    .pop_i      (frame_ready),
    .head_vld_o (frame_valid),
    .head_dat_o (frame_data),
    .level_o    (level)
  );

  assign rx_busy     = (word_idx_q != '0);
  assign frame_abort = abort_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_rx_frame_buffer.sv
module tb_rx_frame_buffer;
  import rx_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         spi_clk;
  logic         spi_w;
  logic [7:0]   mosi;
  logic         frame_ready;
  logic         frame_valid;
  logic [39:0]  frame_data;
  logic [2:0]   level;
  logic         rx_busy;
  logic         frame_abort;
  logic         overflow;

  int checks    = 0;
  int failures  = 0;
  int abort_cnt = 0;
  int ovf_cnt   = 0;
  frame_t sb[$];

  always #5 clk = ~clk;

  rx_frame_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_clk     (spi_clk),
    .spi_w       (spi_w),
    .mosi        (mosi),
    .frame_ready (frame_ready),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .level       (level),
    .rx_busy     (rx_busy),
    .frame_abort (frame_abort),
    .overflow    (overflow)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, where inputs and outputs are settled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_abort) abort_cnt++;
      if (overflow)    ovf_cnt++;
      if (frame_valid && frame_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pop got=%0h expected=none", frame_data);
        end else begin
          frame_t exp_f;
          exp_f = sb.pop_front();
          check("pop_data", {24'h0, frame_data}, {24'h0, exp_f});
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_word(input logic [7:0] w);
    mosi = w;
    tick(1);
    spi_clk = 1'b1;
    tick(4);
    spi_clk = 1'b0;
    tick(4);
  endtask

  task automatic send_head(input frame_t f);
    for (int k = 0; k < 4; k++) send_word(f[k*8 +: 8]);
  endtask

  task automatic send_frame(input frame_t f);
    send_head(f);
    send_word(f[39:32]);
  endtask

  task automatic drain(input string tag);
    frame_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (!frame_valid) break;
    end
    frame_ready = 1'b0;
    tick(1);
    check({tag, "_valid_low"}, {63'h0, frame_valid}, 64'h0);
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'h0);
  endtask

  initial begin
    frame_t f1, f2, f3, f4, f5, f6, f7, f8, f9, f10, fab, fr1, fr2, fnew;
    f1   = 40'h9A78563412;
    f2   = 40'h2524232221;
    f3   = 40'h3534333231;
    f4   = 40'h4544434241;
    f5   = 40'h5554535251;
    f6   = 40'h6564636261;
    f7   = 40'h7574737271;
    f8   = 40'h8584838281;
    f9   = 40'h9594939291;
    f10  = 40'hA5A4A3A2A1;
    fab  = 40'hEEDDCCBBAA;
    fr1  = 40'h0706050403;
    fr2  = 40'h1716151413;
    fnew = 40'h0F1E2D3C4B;

    rst_n = 1'b0; spi_clk = 1'b0; spi_w = 1'b0; mosi = 8'h00; frame_ready = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("rst_valid", {63'h0, frame_valid}, 64'h0);
    check("rst_data",  {24'h0, frame_data}, 64'h0);
    check("rst_level", {61'h0, level}, 64'h0);
    check("rst_busy",  {63'h0, rx_busy}, 64'h0);
    check("rst_abort", {63'h0, frame_abort}, 64'h0);
    check("rst_ovf",   {63'h0, overflow}, 64'h0);
    spi_w = 1'b1;
    tick(4);

    // 1: single frame, latency check on the final spi_clk rise.
    sb.push_back(f1);
    send_head(f1);
    check("t1_busy_mid", {63'h0, rx_busy}, 64'h1);
    mosi = f1[39:32];
    tick(1);
    spi_clk = 1'b1;
    repeat (4) @(negedge clk);
    check("t1_valid_early", {63'h0, frame_valid}, 64'h0);
    @(negedge clk);
    check("t1_valid_on_time", {63'h0, frame_valid}, 64'h1);
    tick(1);
    spi_clk = 1'b0;
    tick(4);
    check("t1_data",  {24'h0, frame_data}, {24'h0, f1});
    check("t1_level", {61'h0, level}, 64'h1);
    check("t1_busy",  {63'h0, rx_busy}, 64'h0);

    // 2: fill to DEPTH, then one more frame is dropped.
    sb.push_back(f2); send_frame(f2);
    sb.push_back(f3); send_frame(f3);
    sb.push_back(f4); send_frame(f4);
    check("t2_level_full", {61'h0, level}, 64'h4);
    check("t2_ovf_none",   64'(ovf_cnt), 64'h0);
    send_frame(f5);
    tick(2);
    check("t2_ovf_once",  64'(ovf_cnt), 64'h1);
    check("t2_level",     {61'h0, level}, 64'h4);
    check("t2_head",      {24'h0, frame_data}, {24'h0, f1});
    check("t2_busy",      {63'h0, rx_busy}, 64'h0);
    drain("t2_drain");

    // 3: frame completes into a full FIFO in the same cycle as a pop.
    sb.push_back(f6); send_frame(f6);
    sb.push_back(f7); send_frame(f7);
    sb.push_back(f8); send_frame(f8);
    sb.push_back(f9); send_frame(f9);
    check("t3_level_full", {61'h0, level}, 64'h4);
    sb.push_back(f10);
    send_head(f10);
    mosi = f10[39:32];
    tick(1);
    spi_clk = 1'b1;
    tick(3);
    frame_ready = 1'b1;
    tick(1);
    frame_ready = 1'b0;
    tick(1);
    spi_clk = 1'b0;
    tick(4);
    check("t3_no_ovf", 64'(ovf_cnt), 64'h1);
    check("t3_level",  {61'h0, level}, 64'h4);
    check("t3_head",   {24'h0, frame_data}, {24'h0, f7});
    drain("t3_drain");

    // 4: abort a 3-word partial frame, then a clean frame.
    send_word(8'h11); send_word(8'h22); send_word(8'h33);
    check("t4_busy_partial", {63'h0, rx_busy}, 64'h1);
    spi_w = 1'b0;
    tick(6);
    check("t4_abort_once", 64'(abort_cnt), 64'h1);
    check("t4_busy_clear", {63'h0, rx_busy}, 64'h0);
    check("t4_level",      {61'h0, level}, 64'h0);
    spi_w = 1'b1;
    tick(4);
    sb.push_back(fab); send_frame(fab);
    tick(2);
    check("t4_level_one", {61'h0, level}, 64'h1);
    check("t4_word0",     {56'h0, frame_data[7:0]}, 64'hAA);
    drain("t4_drain");

    // 5: spi_clk activity with spi_w low is ignored; the fall at index 0 is silent.
    spi_w = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mosi = 8'(8'hC0 + i);
      tick(1);
      spi_clk = 1'b1;
      tick(3);
      spi_clk = 1'b0;
      tick(3);
    end
    check("t5_level",  {61'h0, level}, 64'h0);
    check("t5_busy",   {63'h0, rx_busy}, 64'h0);
    check("t5_abort",  64'(abort_cnt), 64'h1);
    check("t5_ovf",    64'(ovf_cnt), 64'h1);
    check("t5_valid",  {63'h0, frame_valid}, 64'h0);

    // 6: reset mid-frame with two frames queued.
    spi_w = 1'b1;
    tick(4);
    send_frame(fr1);
    send_frame(fr2);
    check("t6_level_two", {61'h0, level}, 64'h2);
    send_word(8'h55); send_word(8'h66);
    check("t6_busy_pre", {63'h0, rx_busy}, 64'h1);
    rst_n = 1'b0;
    #1;
    check("t6_valid", {63'h0, frame_valid}, 64'h0);
    check("t6_data",  {24'h0, frame_data}, 64'h0);
    check("t6_level", {61'h0, level}, 64'h0);
    check("t6_busy",  {63'h0, rx_busy}, 64'h0);
    check("t6_abort", {63'h0, frame_abort}, 64'h0);
    check("t6_ovf",   {63'h0, overflow}, 64'h0);
    tick(3);
    rst_n = 1'b1;
    tick(4);
    sb.push_back(fnew); send_frame(fnew);
    tick(2);
    check("t6_level_new", {61'h0, level}, 64'h1);
    drain("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
